vc_request_buffer: RTL and testbench

Requester-side companion to the two-input rotating prioritizer in the multi-core router datapath. Holds outbound packets in two 2-deep virtual-channel FIFOs (even and odd), selected by the global `polarity` signal. It raises a request to the prioritizer whenever the active channel holds data, and pops a packet on grant. It also tracks how long a request has waited unanswered and flags starvation.

---
 rtl/vc_request_buffer.sv | 107 ++++++++++
 tb/tb_vc_request_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vc_request_buffer.sv
// Requester-side virtual-channel buffer: two 2-deep FIFOs alternately written and read by the
// global polarity phase, with prioritizer request/grant handshake and per-channel starvation tracking.
module vc_request_buffer #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  si,
    input  logic [DATA_WIDTH-1:0] di,
    output logic                  ri,
    output logic                  rq,
    input  logic                  gt,
    output logic                  so,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  starve
);

    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_MAX = 8'hFF;

    logic [1:0] count_q    [2];
    logic [1:0] count_d    [2];
    logic       rd_ptr_q   [2];
    logic       rd_ptr_d   [2];
    logic       wr_ptr_q   [2];
    logic       wr_ptr_d   [2];
    logic [7:0] wait_cnt_q [2];
    logic [7:0] wait_cnt_d [2];
    data_t      mem_q      [2][2];
    data_t      mem_d      [2][2];

    logic wr_ch;
    logic rd_ch;
    logic wr_en;
    logic pop;

    // The write and read channels are always opposite, so a write and a pop never collide.
    assign wr_ch  = polarity;
    assign rd_ch  = ~polarity;

    assign ri     = (count_q[wr_ch] != 2'd2);
    assign rq     = (count_q[rd_ch] != 2'd0);
    assign so     = rq & gt;
    assign wr_en  = si & ri;
    assign pop    = so;
    assign dout   = mem_q[rd_ch][rd_ptr_q[rd_ch]];
    assign starve = (wait_cnt_q[rd_ch] >= LIMIT);

    always_comb begin
        // NOTE: every _d takes its current value first, so no path leaves it unassigned and no latch is inferred.
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        wait_cnt_d = wait_cnt_q;

        if (wr_en) begin
            count_d[wr_ch]  = count_q[wr_ch] + 2'd1;
            wr_ptr_d[wr_ch] = ~wr_ptr_q[wr_ch];
        end

        if (pop) begin
            count_d[rd_ch]  = count_q[rd_ch] - 2'd1;
            rd_ptr_d[rd_ch] = ~rd_ptr_q[rd_ch];
        end

        // Only the read channel's wait counter moves; an idle or granted channel restarts from zero.
        if (!rq || gt) begin
            wait_cnt_d[rd_ch] = 8'd0;
        end else if (wait_cnt_q[rd_ch] != WAIT_MAX) begin
            wait_cnt_d[rd_ch] = wait_cnt_q[rd_ch] + 8'd1;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ch][wr_ptr_q[wr_ch]] = di;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                count_q[ch]    <= 2'd0;
                rd_ptr_q[ch]   <= 1'b0;
                wr_ptr_q[ch]   <= 1'b0;
                wait_cnt_q[ch] <= 8'd0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // NOTE: packet storage is deliberately not reset; counts and pointers decide what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_vc_request_buffer.sv
// Self-checking bench for vc_request_buffer: queue-based reference model compared every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_vc_request_buffer;

    localparam int DW    = 64;
    localparam int LIMIT = 3;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          polarity = 1'b0;
    logic          si       = 1'b0;
    logic [DW-1:0] di       = '0;
    logic          gt       = 1'b0;
    logic          ri;
    logic          rq;
    logic          so;
    logic [DW-1:0] dout;
    logic          starve;

    int n_cmp = 0;
    int n_err = 0;

    vc_request_buffer #(
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk     (clk),
        .reset   (rst_n),
        .polarity(polarity),
        .si      (si),
        .di      (di),
        .ri      (ri),
        .rq      (rq),
        .gt      (gt),
        .so      (so),
        .dout    (dout),
        .starve  (starve)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check64(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per channel plus a plain integer wait count.
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    int            wc[2];

    function automatic int msize(input logic ch);
        return ch ? mq1.size() : mq0.size();
    endfunction

    function automatic logic [DW-1:0] mhead(input logic ch);
        return ch ? mq1[0] : mq0[0];
    endfunction

    logic exp_ri, exp_rq, exp_so, exp_starve, rd;
    int   max_seen = 0;

    initial begin
        wc[0] = 0;
        wc[1] = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                mq0.delete();
                mq1.delete();
                wc[0] = 0;
                wc[1] = 0;
                check1("rst_ri", ri, 1'b1);
                check1("rst_rq", rq, 1'b0);
                check1("rst_so", so, 1'b0);
                check1("rst_starve", starve, 1'b0);
            end else begin
                rd         = ~polarity;
                exp_ri     = (msize(polarity) < 2);
                exp_rq     = (msize(rd) > 0);
                exp_so     = exp_rq & gt;
                exp_starve = (wc[rd] >= LIMIT);
                check1("ri", ri, exp_ri);
                check1("rq", rq, exp_rq);
                check1("so", so, exp_so);
                check1("starve", starve, exp_starve);
                if (exp_so) check64("dout", dout, mhead(rd));
                if (si && exp_ri) begin
                    if (polarity) mq1.push_back(di);
                    else          mq0.push_back(di);
                end
                if (exp_so) begin
                    if (rd) void'(mq1.pop_front());
                    else    void'(mq0.pop_front());
                end
                if (!exp_rq || gt) wc[rd] = 0;
                else if (wc[rd] < 255) wc[rd] = wc[rd] + 1;
                if (msize(1'b0) > max_seen) max_seen = msize(1'b0);
                if (msize(1'b1) > max_seen) max_seen = msize(1'b1);
            end
        end
    end

    task automatic drive(input logic p, input logic s, input logic [DW-1:0] d, input logic g);
        @(negedge clk);
        polarity = p;
        si       = s;
        di       = d;
        gt       = g;
    endtask

    initial begin
        logic p;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single packet through VC0.
        drive(1'b0, 1'b1, 64'hA1, 1'b0);
        #4 check1("t1_ri", ri, 1'b1);
        check1("t1_rq_vc1_empty", rq, 1'b0);
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        #4 check1("t1_rq", rq, 1'b1);
        check64("t1_dout", dout, 64'hA1);
        check1("t1_so", so, 1'b1);
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        #4 check1("t1_vc0_empty", rq, 1'b0);

        // Fill VC1, then drain in order.
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        drive(1'b1, 1'b1, 64'hB1, 1'b0);
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        drive(1'b1, 1'b1, 64'hB2, 1'b0);
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        #4 check1("t2_full_ri", ri, 1'b0);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        #4 check64("t2_dout_b1", dout, 64'hB1);
        check1("t2_so_b1", so, 1'b1);
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        #4 check64("t2_dout_b2", dout, 64'hB2);
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        #4 check1("t2_vc1_empty", rq, 1'b0);

        // Starvation with limit 3: asserts on the 4th ungranted requesting cycle.
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        drive(1'b0, 1'b1, 64'hC0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b0, 64'h0, 1'b0);
            #4 check1("t3_no_starve", starve, 1'b0);
            drive(1'b0, 1'b0, 64'h0, 1'b0);
        end
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        #4 check1("t3_starve", starve, 1'b1);
        check1("t3_so", so, 1'b1);
        check64("t3_dout", dout, 64'hC0);
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        #4 check1("t3_cleared", starve, 1'b0);

        // Grant with both channels empty.
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        #4 check1("t4_so0", so, 1'b0);
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        #4 check1("t4_so1", so, 1'b0);

        // Asynchronous reset with both FIFOs full.
        drive(1'b0, 1'b1, 64'hC1, 1'b0);
        drive(1'b1, 1'b1, 64'hD1, 1'b0);
        drive(1'b0, 1'b1, 64'hC2, 1'b0);
        drive(1'b1, 1'b1, 64'hD2, 1'b0);
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        #1 check1("t5_pre_rq", rq, 1'b1);
        check1("t5_pre_ri", ri, 1'b0);
        rst_n = 1'b0;
        #1 check1("t5_async_rq", rq, 1'b0);
        check1("t5_async_ri", ri, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        drive(1'b0, 1'b1, 64'hE1, 1'b0);
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        #4 check64("t5_fresh_dout", dout, 64'hE1);
        check1("t5_fresh_so", so, 1'b1);

        // Continuous streaming with grant held high.
        for (int i = 0; i < 8; i++) drive(i[0], 1'b1, 64'h100 + 64'(i), 1'b1);
        repeat (4) drive(~polarity, 1'b0, 64'h0, 1'b1);

        // Randomized traffic, then a long ungranted stretch to reach saturation.
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            p        = ~polarity;
            polarity = p;
            si       = ($urandom_range(0, 3) != 0) && (msize(p) < 2 || $urandom_range(0, 9) == 0);
            di       = {$urandom, $urandom};
            gt       = (i >= 1200 && i < 1900) ? 1'b0 : 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        #4 check1("max_occupancy_le_2", (max_seen <= 2), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
